nabp_processing_data_path: RTL

- Initiator side of the filtered-RAM read interface for the processing swappables.
- For one angle and line iteration, the block walks every scan step.
- At each step it computes the projection index s for every partition and reads the filtered RAM through two ports (pv0, pv1).
- It assembles the returned samples into a tap word and presents that word to the processing elements with a one-cycle pe_en strobe.

---
 rtl/nabp_processing_data_path_if.sv | 45 ++++
 rtl/nabp_processing_data_path.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nabp_processing_data_path_if.sv
// Bus bundle between the processing data path (initiator) and its host/RAM
// side.
//   master : used by nabp_processing_data_path.
//            It drives the RAM addresses, the PE strobe/taps and the status.
//   slave  : used by the host / filtered RAM side.
//            It drives start, the fixed-point s inputs and the RAM data.
// Signals:
//   start, s_base, s_scan_step, s_line_step  : line request and s geometry
//   busy, done, scan_itr                     : status
//   pv0_s_val/pv0_val, pv1_s_val/pv1_val     : two filtered-RAM read ports
//   pe_en, pe_taps                           : tap word presented to the PEs
interface nabp_processing_data_path_if #(
  parameter int pImageSize          = 256,
  parameter int pNoOfPartitions     = 4,
  parameter int pSLength            = 9,
  parameter int pFilteredDataLength = 12,
  parameter int pFracBits           = 8
);
  localparam int pAccLength = pSLength + pFracBits + 1;
  localparam int SCAN_W     = $clog2(pImageSize);

  logic                                           start;
  logic signed [pAccLength-1:0]                   s_base;
  logic signed [pAccLength-1:0]                   s_scan_step;
  logic signed [pAccLength-1:0]                   s_line_step;
  logic                                           busy;
  logic                                           done;
  logic [pSLength-1:0]                            pv0_s_val;
  logic [pFilteredDataLength-1:0]                 pv0_val;
  logic [pSLength-1:0]                            pv1_s_val;
  logic [pFilteredDataLength-1:0]                 pv1_val;
  logic                                           pe_en;
  logic [pFilteredDataLength*pNoOfPartitions-1:0] pe_taps;
  logic [SCAN_W-1:0]                              scan_itr;

  modport master (
    input  start, s_base, s_scan_step, s_line_step, pv0_val, pv1_val,
    output busy, done, pv0_s_val, pv1_s_val, pe_en, pe_taps, scan_itr
  );

  modport slave (
    output start, s_base, s_scan_step, s_line_step, pv0_val, pv1_val,
    input  busy, done, pv0_s_val, pv1_s_val, pe_en, pe_taps, scan_itr
  );
endinterface

// File: rtl/nabp_processing_data_path.sv
// Filtered-RAM read initiator for the processing swappables.
// For one angle/line iteration it walks pImageSize scan steps.
// At each step it:
//   - computes the rounded projection index s of every partition;
//   - reads even partitions through pv0 and odd partitions through pv1;
//   - collects the returned samples into a tap word;
//   - presents that word to the PEs with a one-cycle pe_en strobe.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : nabp_processing_data_path_if.master
//            (start/s_* in, busy/done/scan_itr out,
//             pv0/pv1 address out and data in, pe_en/pe_taps out)
module nabp_processing_data_path #(
  parameter int pImageSize          = 256,
  parameter int pNoOfPartitions     = 4,
  parameter int pSLength            = 9,
  parameter int pProjectionLineSize = 367,
  parameter int pFilteredDataLength = 12,
  parameter int pFracBits           = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  nabp_processing_data_path_if.master     bus
);
  localparam int ACC_W  = pSLength + pFracBits + 1;
  localparam int W      = pFilteredDataLength;
  localparam int H      = pNoOfPartitions / 2;
  localparam int K_W    = (H > 1) ? $clog2(H) : 1;
  localparam int SCAN_W = $clog2(pImageSize);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(pProjectionLineSize - 1);
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (pFracBits - 1));

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;

  // floor(a + 0.5): add half an LSB of the integer part, then arithmetic shift
  function automatic logic signed [ACC_W-1:0] round_s(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a + HALF;
    return t >>> pFracBits;
  endfunction

  function automatic logic in_range(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = round_s(a);
    return (s >= 0) && (s <= S_MAX);
  endfunction

  // Out-of-range s reads address 0; the matching tap is zeroed at capture
  function automatic logic [pSLength-1:0] to_addr(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = round_s(a);
    return in_range(a) ? s[pSLength-1:0] : '0;
  endfunction

  state_t                  state_q;
  logic signed [ACC_W-1:0] s_row_q, scan_step_q, line_step_q;
  logic signed [ACC_W-1:0] a0_q, a1_q, a0_d, a1_d, two_line;
  logic                    load_acc;
  logic [K_W-1:0]          k_q;
  logic [SCAN_W-1:0]       scan_itr_q;
  logic                    busy_q, done_q, pe_en_q;
  logic [pSLength-1:0]     pv0_q, pv1_q;
  logic                    ok0_q, ok1_q;
  logic                    fetch_vld_p1, ok0_p1, ok1_p1;
  logic [K_W-1:0]          k_p1;
  logic [K_W:0]            idx_e, idx_o;
  logic [W-1:0]            stg_q [pNoOfPartitions];
  logic [W-1:0]            stg_d [pNoOfPartitions];
  logic [W-1:0]            taps_q [pNoOfPartitions];

  assign two_line = line_step_q <<< 1;
  assign idx_e    = {k_p1, 1'b0};
  assign idx_o    = {k_p1, 1'b1};

  // Accumulator next values.
  // Partition pairs are walked incrementally, so no multipliers are needed.
  always_comb begin
    a0_d     = a0_q;
    a1_d     = a1_q;
    load_acc = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        a0_d     = bus.s_base;
        a1_d     = bus.s_base + bus.s_line_step;
        load_acc = 1'b1;
      end
      FETCH: if (k_q != K_W'(H - 1)) begin
        a0_d     = a0_q + two_line;
        a1_d     = a1_q + two_line;
        load_acc = 1'b1;
      end
      PRESENT: if (scan_itr_q != SCAN_W'(pImageSize - 1)) begin
        a0_d     = s_row_q + scan_step_q;
        a1_d     = a0_d + line_step_q;
        load_acc = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM data seen this cycle belongs to the pair addressed last cycle
  always_comb begin
    for (int i = 0; i < pNoOfPartitions; i++) stg_d[i] = stg_q[i];
    if (fetch_vld_p1) begin
      stg_d[idx_e] = ok0_p1 ? bus.pv0_val : '0;
      stg_d[idx_o] = ok1_p1 ? bus.pv1_val : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_row_q      <= '0;
      scan_step_q  <= '0;
      line_step_q  <= '0;
      a0_q         <= '0;
      a1_q         <= '0;
      k_q          <= '0;
      scan_itr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pe_en_q      <= 1'b0;
      pv0_q        <= '0;
      pv1_q        <= '0;
      ok0_q        <= 1'b0;
      ok1_q        <= 1'b0;
      fetch_vld_p1 <= 1'b0;
      ok0_p1       <= 1'b0;
      ok1_p1       <= 1'b0;
      k_p1         <= '0;
      for (int i = 0; i < pNoOfPartitions; i++) begin
        stg_q[i]  <= '0;
        taps_q[i] <= '0;
      end
    end else begin
      // Stage p1: address-side tags delayed to line up with RAM data
      fetch_vld_p1 <= (state_q == FETCH);
      k_p1         <= k_q;
      ok0_p1       <= ok0_q;
      ok1_p1       <= ok1_q;
      for (int i = 0; i < pNoOfPartitions; i++) stg_q[i] <= stg_d[i];

      done_q  <= 1'b0;
      pe_en_q <= 1'b0;

      if (load_acc) begin
        a0_q  <= a0_d;
        a1_q  <= a1_d;
        pv0_q <= to_addr(a0_d);
        pv1_q <= to_addr(a1_d);
        ok0_q <= in_range(a0_d);
        ok1_q <= in_range(a1_d);
      end

      case (state_q)
        IDLE: if (bus.start) begin
          s_row_q     <= bus.s_base;
          scan_step_q <= bus.s_scan_step;
          line_step_q <= bus.s_line_step;
          k_q         <= '0;
          scan_itr_q  <= '0;
          busy_q      <= 1'b1;
          state_q     <= FETCH;
        end
        FETCH: begin
          if (k_q == K_W'(H - 1)) state_q <= WAIT;
          else                    k_q     <= k_q + K_W'(1);
        end
        WAIT: begin
          // stg_d already holds the final pair arriving this cycle
          for (int i = 0; i < pNoOfPartitions; i++) taps_q[i] <= stg_d[i];
          pe_en_q <= 1'b1;
          state_q <= PRESENT;
        end
        PRESENT: begin
          if (scan_itr_q == SCAN_W'(pImageSize - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            s_row_q    <= s_row_q + scan_step_q;
            scan_itr_q <= scan_itr_q + SCAN_W'(1);
            k_q        <= '0;
            state_q    <= FETCH;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pe_en     = pe_en_q;
  assign bus.pv0_s_val = pv0_q;
  assign bus.pv1_s_val = pv1_q;
  assign bus.scan_itr  = scan_itr_q;

  for (genvar i = 0; i < pNoOfPartitions; i++) begin : g_taps
    assign bus.pe_taps[i*W +: W] = taps_q[i];
  end
endmodule
